// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b, LSB first.
// A single borrow flop ripples one bit per clock through SHIFT. A start/busy/done
// handshake frames each operation. The optional signed-overflow output is enabled
// by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVERFLOW_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  logic [WIDTH-1:0] r_res;
  logic [CW-1:0]    r_cnt;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrowOut;
  logic             w_d;
  logic             w_borrowNext;
  logic             w_last;
  logic             w_accept;

  assign w_d          = r_aSh[0] ^ r_bSh[0] ^ r_borrow;
  assign w_borrowNext = (~r_aSh[0] & r_bSh[0]) | (~(r_aSh[0] ^ r_bSh[0]) & r_borrow);
  assign w_last       = (r_cnt == CW'(WIDTH - 1));
  assign w_accept     = (r_state == IDLE) && start;

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrowOut;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_stateNext;
  end

  // Next-state decode: IDLE waits for start, SHIFT runs WIDTH edges, DONE lasts one cycle.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (start) w_stateNext = SHIFT;
      SHIFT:   if (w_last) w_stateNext = DONE;
      DONE:    w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, ripple one bit per SHIFT edge, publish on the last bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aSh       <= '0;
      r_bSh       <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_diff      <= '0;
      r_borrowOut <= 1'b0;
    end else begin
      r_busy <= (w_stateNext == SHIFT);
      r_done <= (w_stateNext == DONE);
      if (w_accept) begin
        r_aSh    <= a;
        r_bSh    <= b;
        r_res    <= '0;
        r_cnt    <= '0;
        r_borrow <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_res    <= {w_d, r_res[WIDTH-1:1]};
        r_aSh    <= r_aSh >> 1;
        r_bSh    <= r_bSh >> 1;
        r_borrow <= w_borrowNext;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_diff      <= {w_d, r_res[WIDTH-1:1]};
          r_borrowOut <= w_borrowNext;
        end
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_aMsb;
  logic r_bMsb;
  logic r_overflow;

  assign overflow = r_overflow;

  // Signed overflow from captured operand signs; the last serial bit is the result MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aMsb     <= 1'b0;
      r_bMsb     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_accept) begin
        r_aMsb <= a[WIDTH-1];
        r_bMsb <= b[WIDTH-1];
      end else if ((r_state == SHIFT) && w_last) begin
        r_overflow <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
      end
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for serial_subtractor at WIDTH=8.
// Stimulus pushes expected results; a negedge monitor pops them on every done pulse.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int   total = 0;
  int   bad = 0;
  int   cycle = 0;
  int   lastDone = -1;
  bit   checkSpacing = 0;
  bit   prevDone = 0;
  exp_t expQ[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    .overflow   (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, actual, expected, cycle);
    end
  endtask

  // Monitor: on each done pulse pop the scoreboard, check pulse width and optional spacing.
  always @(negedge clk) begin
    exp_t e;
    cycle++;
    if (!reset && done) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = expQ.pop_front();
        checkOutput("diff", 32'(diff), 32'(e.diff));
        checkOutput("borrow_out", 32'(borrow_out), 32'(e.borrow));
`ifdef SERIAL_SUB_OVERFLOW_EN
        checkOutput("overflow", 32'(overflow), 32'(e.ovf));
`endif
      end
      checkOutput("done_width", 32'(prevDone), 32'd0);
      if (checkSpacing && lastDone >= 0)
        checkOutput("done_spacing", 32'(cycle - lastDone), 32'(W + 2));
      lastDone = cycle;
    end
    prevDone = done;
  end

  // Wait for IDLE, present one operation, then count busy cycles until done.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic [W-1:0] expDiff, input logic expBorrow,
                               input logic expOvf, input bit holdStart);
    int   guard;
    int   busyCnt;
    exp_t e;
    guard = 0;
    while (!(busy == 1'b0 && done == 1'b0) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("idle_timeout", 32'd1, 32'd0);
    a = av;
    b = bv;
    start = 1'b1;
    e.diff = expDiff;
    e.borrow = expBorrow;
    e.ovf = expOvf;
    expQ.push_back(e);
    @(negedge clk);
    if (!holdStart) start = 1'b0;
    a = ~av;
    b = av ^ 8'h5A;
    busyCnt = 0;
    guard = 0;
    while (!done && guard < 50) begin
      if (busy) busyCnt++;
      a = a + 8'h13;
      b = b - 8'h07;
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("done_timeout", 32'd1, 32'd0);
    checkOutput("busy_cycles", 32'(busyCnt), 32'(W));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] rd;
    int           guard;
    bit           sawDone;

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_diff", 32'(diff), 32'd0);
    checkOutput("reset_borrow", 32'(borrow_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors with hand-computed diff / borrow / signed overflow.
    applyStimulus(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    applyStimulus(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);

    // Diff must hold the previous result while the next one shifts.
    @(negedge clk);
    a = 8'hAA;
    b = 8'h11;
    start = 1'b1;
    expQ.push_back('{diff: 8'h99, borrow: 1'b0, ovf: 1'b0});
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("diff_hold", 32'(diff), 32'h0F);
    guard = 0;
    while (!done && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) checkOutput("hold_done_timeout", 32'd1, 32'd0);

    // start held high, operands disturbed during SHIFT: back-to-back ops 10 cycles apart.
    start = 1'b1;
    lastDone = -1;
    checkSpacing = 1'b1;
    applyStimulus(8'h9C, 8'h27, 8'h75, 1'b0, 1'b1, 1'b1);
    applyStimulus(8'h27, 8'h9C, 8'h8B, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1);
    start = 1'b0;
    @(negedge clk);
    checkSpacing = 1'b0;

    // Complete 0xFF - 0x01, then abort 0x00 - 0x01 with reset at shift cycle 4.
    applyStimulus(8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = 8'h00;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_diff", 32'(diff), 32'd0);
    checkOutput("abort_borrow", 32'(borrow_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    checkOutput("abort_no_done", 32'(sawDone), 32'd0);
    applyStimulus(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);

    // Random operands against a reference model.
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rd = ra - rb;
      applyStimulus(ra, rb, rd, (ra < rb), ((ra[W-1] != rb[W-1]) && (rd[W-1] != ra[W-1])), 1'b0);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
